// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes, opcode legality check and issuer FSM states
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd3;
    localparam logic [OP_W-1:0] OP_OR   = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd5;
    localparam logic [OP_W-1:0] OP_AND  = 4'd6;
    localparam logic [OP_W-1:0] OP_NAND = 4'd7;
    localparam logic [OP_W-1:0] OP_NOR  = 4'd8;
    localparam logic [OP_W-1:0] OP_NOT  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PUSH = 2'd2
    } state_e;

    // Legal opcodes form the contiguous range OP_ADD..OP_NOT.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/alu_issuer_rsp_fifo.sv
// rtl/alu_issuer_rsp_fifo.sv - synchronous response FIFO with occupancy count
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data (ignored when full)
//   push_data   : entry to write
//   pop         : drop the head entry (ignored when empty)
//   pop_data    : current head entry
//   count       : number of stored entries, 0..DEPTH
module rsp_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop  && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leave the occupancy unchanged.
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/alu_issuer.sv
// rtl/alu_issuer.sv - command front-end that drives the ALU and returns tagged results
//
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             : command handshake
//   cmd_a, cmd_b, cmd_op, cmd_tag   : operands, opcode, request tag
//   alu_a, alu_b, alu_opcode        : registered ALU inputs, held between commands
//   alu_result                      : ALU output, sampled ALU_LAT cycles after issue
//   rsp_valid/rsp_ready             : response handshake (head of response FIFO)
//   rsp_result, rsp_tag, rsp_err    : response payload, zero while no response is held
//   op_count                        : responses popped since reset, wrapping
module alu_issuer #(
    parameter int DATA_W    = 16,
    parameter int TAG_W     = 4,
    parameter int ALU_LAT   = 1,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [3:0]        cmd_op,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic [15:0]       op_count
);

    import alu_pkg::*;

    localparam int ENT_W  = DATA_W + TAG_W + 1;
    localparam int CNT_FW = $clog2(RSP_DEPTH + 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [3:0]        wait_q, wait_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              err_q, err_d;
    logic [15:0]       op_count_q, op_count_d;
    // Low during reset and for the edge that ends it, so cmd_ready stays 0
    // while rst_n is asserted even though the FSM sits in IDLE.
    logic              run_q, run_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic [ENT_W-1:0]  fifo_head;
    logic [CNT_FW-1:0] fifo_count;
    logic              fifo_empty;

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        wait_d     = wait_q;
        res_d      = res_q;
        tag_d      = tag_q;
        err_d      = err_q;
        run_d      = 1'b1;
        cmd_ready  = 1'b0;
        fifo_push  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A command is only taken if its response is sure to find room.
                cmd_ready = run_q && (fifo_count < CNT_FW'(RSP_DEPTH));
                if (cmd_valid && cmd_ready) begin
                    tag_d = cmd_tag;
                    if (is_legal_op(cmd_op)) begin
                        alu_a_d  = cmd_a;
                        alu_b_d  = cmd_b;
                        alu_op_d = cmd_op;
                        wait_d   = 4'(ALU_LAT);
                        state_d  = ST_WAIT;
                    end else begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_PUSH;
                    end
                end
            end
            ST_WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_q == 4'd1) begin
                    res_d   = alu_result;
                    err_d   = 1'b0;
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                fifo_push = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        fifo_empty = (fifo_count == '0);
        fifo_pop   = !fifo_empty && rsp_ready;
        op_count_d = op_count_q + {15'd0, fifo_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            wait_q     <= '0;
            res_q      <= '0;
            tag_q      <= '0;
            err_q      <= 1'b0;
            op_count_q <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            wait_q     <= wait_d;
            res_q      <= res_d;
            tag_q      <= tag_d;
            err_q      <= err_d;
            op_count_q <= op_count_d;
            run_q      <= run_d;
        end
    end

    rsp_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({res_q, tag_q, err_q}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count)
    );

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = !fifo_empty;
    // Stale slots stay in the FIFO after a pop; mask them when empty.
    assign rsp_result = fifo_empty ? '0   : fifo_head[ENT_W-1 -: DATA_W];
    assign rsp_tag    = fifo_empty ? '0   : fifo_head[TAG_W:1];
    assign rsp_err    = fifo_empty ? 1'b0 : fifo_head[0];
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_issuer.sv
// tb/tb_alu_issuer.sv - scoreboard testbench for alu_issuer
module tb_alu_issuer;

    typedef struct packed {
        logic [3:0]  tag;
        logic [15:0] res;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n, rst_n4;
    logic        cmd_valid, cmd_valid4;
    logic        cmd_ready, cmd_ready4;
    logic [15:0] cmd_a, cmd_b;
    logic [3:0]  cmd_op, cmd_tag;
    logic [15:0] alu_a, alu_b, alu_a4, alu_b4;
    logic [3:0]  alu_opcode, alu_opcode4;
    logic [15:0] alu_result, alu_result4;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic        rsp_valid4, rsp_ready4, rsp_err4;
    logic [15:0] rsp_result, rsp_result4;
    logic [3:0]  rsp_tag, rsp_tag4;
    logic [15:0] op_count, op_count4;

    int   checks = 0;
    int   errors = 0;
    int   ghost4 = 0;
    rsp_t exp_q[$];
    logic stalled = 1'b0;
    rsp_t held;

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
        case (op)
            4'd2:    return a + b;
            4'd3:    return a - b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return a & b;
            4'd7:    return ~(a & b);
            4'd8:    return ~(a | b);
            4'd9:    return ~a;
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_result  = alu_f(alu_a, alu_b, alu_opcode);
    assign alu_result4 = alu_f(alu_a4, alu_b4, alu_opcode4);

    alu_issuer #(.DATA_W(16), .TAG_W(4), .ALU_LAT(1), .RSP_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .op_count(op_count)
    );

    alu_issuer #(.DATA_W(16), .TAG_W(4), .ALU_LAT(4), .RSP_DEPTH(2)) dut4 (
        .clk(clk), .rst_n(rst_n4),
        .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_opcode(alu_opcode4), .alu_result(alu_result4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
        .rsp_result(rsp_result4), .rsp_tag(rsp_tag4), .rsp_err(rsp_err4),
        .op_count(op_count4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: sampled mid-cycle, when inputs and outputs are both settled.
    always @(negedge clk) begin
        rsp_t got;
        got = '{tag: rsp_tag, res: rsp_result, err: rsp_err};
        if (rst_n) begin
            if (stalled) begin
                checks++;
                if (!rsp_valid || got != held) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b %h expected v=1 %h", rsp_valid, got, held);
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: got %h expected none", got);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    if (got != e) begin
                        errors++;
                        $display("FAIL rsp: got tag=%h res=%h err=%b expected tag=%h res=%h err=%b",
                                 got.tag, got.res, got.err, e.tag, e.res, e.err);
                    end
                end
            end
            stalled = rsp_valid && !rsp_ready;
            held    = got;
        end else begin
            stalled = 1'b0;
        end
        if (rsp_valid4) ghost4++;
    end

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                        input logic [3:0] tag, input logic [15:0] er, input logic ee);
        int n = 0;
        exp_q.push_back('{tag: tag, res: er, err: ee});
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("cmd_accept", 32'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("drain_empty", 32'(exp_q.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; rst_n4 = 1'b0;
        cmd_valid = 1'b0; cmd_valid4 = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
        rsp_ready = 1'b1; rsp_ready4 = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_alu_a", 32'(alu_a), 0);
        chk("reset_op_count", 32'(op_count), 0);
        chk("reset_rsp_result", 32'(rsp_result), 0);
        rst_n = 1'b1; rst_n4 = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(cmd_ready), 1);

        // ADD latency: handshake cycle 0, response in cycle 3.
        send(16'h1234, 16'h0FFF, 4'd2, 4'd3, 16'h2233, 1'b0);
        @(negedge clk); chk("add_lat_c1", 32'(rsp_valid), 0);
        @(negedge clk); chk("add_lat_c2", 32'(rsp_valid), 0);
        @(negedge clk); chk("add_lat_c3", 32'(rsp_valid), 1);
        @(posedge clk); #1;
        chk("op_count_1", 32'(op_count), 1);

        // SUB wrap then NOT.
        send(16'h0001, 16'h0002, 4'd3, 4'd4, 16'hFFFF, 1'b0);
        send(16'h00FF, 16'hAAAA, 4'd9, 4'd5, 16'hFF00, 1'b0);
        drain();
        chk("alu_opcode_hold_not", 32'(alu_opcode), 9);
        chk("op_count_3", 32'(op_count), 3);

        // Illegal opcode after an ADD.
        send(16'h1111, 16'h2222, 4'd2, 4'd6, 16'h3333, 1'b0);
        drain();
        send(16'hDEAD, 16'hBEEF, 4'hF, 4'd7, 16'h0000, 1'b1);
        @(negedge clk); chk("ill_lat_c1", 32'(rsp_valid), 0);
        @(negedge clk); chk("ill_lat_c2", 32'(rsp_valid), 1);
        drain();
        chk("ill_alu_a", 32'(alu_a), 32'h1111);
        chk("ill_alu_b", 32'(alu_b), 32'h2222);
        chk("ill_alu_opcode", 32'(alu_opcode), 2);

        // Backpressure with a two-entry FIFO.
        rsp_ready = 1'b0;
        send(16'h0001, 16'h0001, 4'd2, 4'd1, 16'h0002, 1'b0);
        send(16'h0002, 16'h0002, 4'd2, 4'd2, 16'h0004, 1'b0);
        exp_q.push_back('{tag: 4'd3, res: 16'h0006, err: 1'b0});
        cmd_a = 16'h0003; cmd_b = 16'h0003; cmd_op = 4'd2; cmd_tag = 4'd3; cmd_valid = 1'b1;
        repeat (6) @(negedge clk);
        chk("bp_ready_low", 32'(cmd_ready), 0);
        chk("bp_head_valid", 32'(rsp_valid), 1);
        chk("bp_head_tag", 32'(rsp_tag), 1);
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready_after_pop", 32'(cmd_ready), 1);
        @(posedge clk); #1; cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_op_count_mid", 32'(op_count), 6);
        rsp_ready = 1'b1;
        drain();
        chk("op_count_8", 32'(op_count), 8);

        // Reset while the ALU_LAT=4 instance is waiting.
        cmd_a = 16'h4321; cmd_b = 16'h1111; cmd_op = 4'd2; cmd_tag = 4'd9; cmd_valid4 = 1'b1;
        @(negedge clk);
        chk("l4_ready", 32'(cmd_ready4), 1);
        @(posedge clk); #1; cmd_valid4 = 1'b0;
        @(posedge clk); #3;
        chk("l4_alu_a_issued", 32'(alu_a4), 32'h4321);
        rst_n4 = 1'b0;
        #1;
        chk("l4_rst_alu_a", 32'(alu_a4), 0);
        chk("l4_rst_alu_b", 32'(alu_b4), 0);
        chk("l4_rst_alu_opcode", 32'(alu_opcode4), 0);
        chk("l4_rst_cmd_ready", 32'(cmd_ready4), 0);
        chk("l4_rst_rsp_valid", 32'(rsp_valid4), 0);
        @(negedge clk); rst_n4 = 1'b1;
        @(posedge clk); #1;
        chk("l4_ready_after_release", 32'(cmd_ready4), 1);
        repeat (20) @(posedge clk);
        chk("l4_no_ghost_rsp", 32'(ghost4), 0);

        // op_count wrap.
        @(posedge clk); #1;
        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        @(negedge clk);
        chk("op_count_preload", 32'(op_count), 32'hFFFF);
        @(posedge clk); #1;
        send(16'h0005, 16'h0006, 4'd0, 4'hA, 16'h0000, 1'b1);
        drain();
        chk("op_count_wrap", 32'(op_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
